// File: rtl/pong_rally_engine_pkg.sv
// Shared definitions for the two-player pong rally engine: state codes,
// server identity, LED pattern constants and a width helper.
package pong_rally_engine_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_MOVE_R    = 3'd1,
        S_MOVE_L    = 3'd2,
        S_FLASH_ON  = 3'd3,
        S_FLASH_OFF = 3'd4
    } state_t;

    typedef enum logic {
        SERVER_LEFT  = 1'b0,
        SERVER_RIGHT = 1'b1
    } server_t;

    // Flash patterns, sliced down to the bar width by the user (bars up to 64 LEDs).
    localparam logic [63:0] ALL_ON  = '1;
    localparam logic [63:0] ALL_OFF = '0;

    // Bits needed to index value distinct positions; never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pong_rally_engine_rise_detect.sv
// One-bit rising-edge detector: compares the live input against the sample
// taken on the previous clock, so an edge is visible in the cycle it arrives.
module pong_rally_engine_rise_detect (
    input  logic Clk,
    input  logic r_n,
    input  logic sig,
    output logic rise
);

    logic prev_reg;

    // Remember last cycle's level of the button.
    always_ff @(posedge Clk or negedge r_n) begin
        if (!r_n) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sig;
        end
    end

    assign rise = sig & ~prev_reg;

endmodule

// File: rtl/pong_rally_engine.sv
// Two-player pong on an LED bar: a one-hot ball moves one LED per tick,
// paddles return it at the ends, misses score a point and trigger a flash.
module pong_rally_engine
    import pong_rally_engine_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int HIT_W          = 7,
    parameter int LEVEL_W        = 4,
    parameter int HITS_PER_LEVEL = 4,
    parameter int FLASH_COUNT    = 3,
    parameter int SCORE_W        = 4
) (
    input  logic               Clk,
    input  logic               r_n,
    input  logic               b,
    input  logic               p_l,
    input  logic               p_r,
    input  logic               tick,
    output logic [WIDTH-1:0]   out,
    output logic [HIT_W-1:0]   hit,
    output logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               busy
);

    localparam int POS_W   = clog2(WIDTH);
    localparam int FLASH_W = clog2(FLASH_COUNT);
    localparam int SUB_W   = clog2(HITS_PER_LEVEL);

    localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(WIDTH - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_COUNT - 1);
    localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(HITS_PER_LEVEL - 1);

    localparam logic [WIDTH-1:0] LED_ALL_ON  = ALL_ON[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LED_ALL_OFF = ALL_OFF[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LED_LEFT    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LED_RIGHT   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_reg;
    server_t              server_reg;
    logic [POS_W-1:0]     pos_reg;
    logic [FLASH_W-1:0]   flash_cnt_reg;
    logic [SUB_W-1:0]     sub_cnt_reg;
    logic                 ret_r_reg;
    logic                 ret_l_reg;
    logic [WIDTH-1:0]     out_reg;
    logic                 busy_reg;
    logic [HIT_W-1:0]     hit_reg;
    logic [LEVEL_W-1:0]   level_reg;
    logic [SCORE_W-1:0]   score_l_reg;
    logic [SCORE_W-1:0]   score_r_reg;

    // Button edge detectors: index 0 = serve, 1 = left paddle, 2 = right paddle.
    logic [2:0] btn_raw;
    logic [2:0] btn_rise;
    assign btn_raw = {p_r, p_l, b};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rise
            pong_rally_engine_rise_detect u_rise (
                .Clk  (Clk),
                .r_n  (r_n),
                .sig  (btn_raw[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    logic rise_b, rise_pl, rise_pr;
    assign rise_b  = btn_rise[0];
    assign rise_pl = btn_rise[1];
    assign rise_pr = btn_rise[2];

    // Rally events; a paddle edge landing on the deciding tick still counts.
    logic at_right, at_left;
    logic serve, return_r, return_l, miss_r, miss_l;
    assign at_right = (pos_reg == POS_MAX);
    assign at_left  = (pos_reg == '0);
    assign serve    = (state_reg == S_WAIT) && rise_b;
    assign return_r = (state_reg == S_MOVE_R) && tick && at_right && (ret_r_reg || rise_pr);
    assign return_l = (state_reg == S_MOVE_L) && tick && at_left  && (ret_l_reg || rise_pl);
    assign miss_r   = (state_reg == S_MOVE_R) && tick && at_right && !(ret_r_reg || rise_pr);
    assign miss_l   = (state_reg == S_MOVE_L) && tick && at_left  && !(ret_l_reg || rise_pl);

    // Main game FSM; the LED pattern and busy are registered alongside the state.
    always_ff @(posedge Clk or negedge r_n) begin
        if (!r_n) begin
            state_reg     <= S_WAIT;
            server_reg    <= SERVER_LEFT;
            pos_reg       <= '0;
            flash_cnt_reg <= '0;
            ret_r_reg     <= 1'b0;
            ret_l_reg     <= 1'b0;
            out_reg       <= LED_LEFT;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (rise_b) begin
                        busy_reg <= 1'b1;
                        if (server_reg == SERVER_LEFT) begin
                            state_reg <= S_MOVE_R;
                            pos_reg   <= '0;
                            out_reg   <= LED_LEFT;
                        end else begin
                            state_reg <= S_MOVE_L;
                            pos_reg   <= POS_MAX;
                            out_reg   <= LED_RIGHT;
                        end
                    end
                end
                S_MOVE_R: begin
                    // Only an edge while the ball sits on the last LED arms a return.
                    if (at_right && rise_pr) begin
                        ret_r_reg <= 1'b1;
                    end
                    if (tick) begin
                        if (!at_right) begin
                            pos_reg <= pos_reg + 1'b1;
                            out_reg <= LED_LEFT << (pos_reg + 1'b1);
                        end else if (return_r) begin
                            state_reg <= S_MOVE_L;
                            pos_reg   <= POS_MAX - 1'b1;
                            out_reg   <= LED_LEFT << (POS_MAX - 1'b1);
                            ret_r_reg <= 1'b0;
                        end else begin
                            server_reg    <= SERVER_RIGHT;
                            state_reg     <= S_FLASH_ON;
                            flash_cnt_reg <= '0;
                            out_reg       <= LED_ALL_ON;
                        end
                    end
                end
                S_MOVE_L: begin
                    if (at_left && rise_pl) begin
                        ret_l_reg <= 1'b1;
                    end
                    if (tick) begin
                        if (!at_left) begin
                            pos_reg <= pos_reg - 1'b1;
                            out_reg <= LED_LEFT << (pos_reg - 1'b1);
                        end else if (return_l) begin
                            state_reg <= S_MOVE_R;
                            pos_reg   <= POS_W'(1);
                            out_reg   <= LED_LEFT << 1;
                            ret_l_reg <= 1'b0;
                        end else begin
                            server_reg    <= SERVER_LEFT;
                            state_reg     <= S_FLASH_ON;
                            flash_cnt_reg <= '0;
                            out_reg       <= LED_ALL_ON;
                        end
                    end
                end
                S_FLASH_ON: begin
                    if (tick) begin
                        state_reg <= S_FLASH_OFF;
                        out_reg   <= LED_ALL_OFF;
                    end
                end
                S_FLASH_OFF: begin
                    if (tick) begin
                        if (flash_cnt_reg == FLASH_LAST) begin
                            state_reg <= S_WAIT;
                            busy_reg  <= 1'b0;
                            out_reg   <= (server_reg == SERVER_LEFT) ? LED_LEFT : LED_RIGHT;
                        end else begin
                            state_reg     <= S_FLASH_ON;
                            flash_cnt_reg <= flash_cnt_reg + 1'b1;
                            out_reg       <= LED_ALL_ON;
                        end
                    end
                end
                default: begin
                    state_reg <= S_WAIT;
                    out_reg   <= LED_ALL_OFF;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Rally statistics: cleared by a serve, bumped by every return, saturating.
    always_ff @(posedge Clk or negedge r_n) begin
        if (!r_n) begin
            hit_reg     <= '0;
            level_reg   <= '0;
            sub_cnt_reg <= '0;
        end else if (serve) begin
            hit_reg     <= '0;
            level_reg   <= '0;
            sub_cnt_reg <= '0;
        end else if (return_r || return_l) begin
            if (hit_reg != '1) begin
                hit_reg <= hit_reg + 1'b1;
            end
            if (sub_cnt_reg == SUB_LAST) begin
                sub_cnt_reg <= '0;
                if (level_reg != '1) begin
                    level_reg <= level_reg + 1'b1;
                end
            end else begin
                sub_cnt_reg <= sub_cnt_reg + 1'b1;
            end
        end
    end

    // Scores survive serves and only clear on reset; a miss credits the opponent.
    always_ff @(posedge Clk or negedge r_n) begin
        if (!r_n) begin
            score_l_reg <= '0;
            score_r_reg <= '0;
        end else begin
            if (miss_r && (score_l_reg != '1)) begin
                score_l_reg <= score_l_reg + 1'b1;
            end
            if (miss_l && (score_r_reg != '1)) begin
                score_r_reg <= score_r_reg + 1'b1;
            end
        end
    end

    assign out     = out_reg;
    assign busy    = busy_reg;
    assign hit     = hit_reg;
    assign level   = level_reg;
    assign score_l = score_l_reg;
    assign score_r = score_r_reg;

endmodule

// File: tb/tb_pong_rally_engine.sv
// Bench for pong_rally_engine: a game-level reference model checked every
// cycle, plus hand-computed literal checks along a directed rally script.
module tb_pong_rally_engine;

    localparam int W   = 8;
    localparam int FC  = 3;
    localparam int HPL = 4;

    logic       Clk;
    logic       r_n;
    logic       b, p_l, p_r, tick;
    logic [7:0] out;
    logic [6:0] hit;
    logic [3:0] level;
    logic [3:0] score_l, score_r;
    logic       busy;

    int vectors;
    int errors;
    bit cmp_en;

    pong_rally_engine #(
        .WIDTH          (W),
        .HIT_W          (7),
        .LEVEL_W        (4),
        .HITS_PER_LEVEL (HPL),
        .FLASH_COUNT    (FC),
        .SCORE_W        (4)
    ) dut (
        .Clk     (Clk),
        .r_n     (r_n),
        .b       (b),
        .p_l     (p_l),
        .p_r     (p_r),
        .tick    (tick),
        .out     (out),
        .hit     (hit),
        .level   (level),
        .score_l (score_l),
        .score_r (score_r),
        .busy    (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model (game rules, not state codes) --------
    // mode: 0 = waiting for serve, 1 = ball in play, 2 = flashing after a miss
    int m_mode, m_ball, m_dir, m_server, m_returns, m_fk, m_sl, m_sr;
    bit m_armed;
    bit q_b, q_l, q_r;
    bit e_b, e_l, e_r, m_at_end, m_edge;

    always @(posedge Clk or negedge r_n) begin
        if (!r_n) begin
            m_mode = 0; m_ball = 0; m_dir = 1; m_server = 0; m_returns = 0;
            m_fk = 0; m_sl = 0; m_sr = 0; m_armed = 0;
            q_b = 0; q_l = 0; q_r = 0;
        end else begin
            e_b = b && !q_b;
            e_l = p_l && !q_l;
            e_r = p_r && !q_r;
            q_b = b; q_l = p_l; q_r = p_r;
            if (m_mode == 0) begin
                if (e_b) begin
                    m_returns = 0;
                    m_mode    = 1;
                    m_ball    = (m_server == 1) ? W - 1 : 0;
                    m_dir     = (m_server == 1) ? -1 : 1;
                    m_armed   = 0;
                end
            end else if (m_mode == 1) begin
                m_at_end = (m_dir > 0) ? (m_ball == W - 1) : (m_ball == 0);
                m_edge   = (m_dir > 0) ? e_r : e_l;
                if (m_at_end && m_edge) m_armed = 1;
                if (tick) begin
                    if (!m_at_end) begin
                        m_ball = m_ball + m_dir;
                    end else if (m_armed) begin
                        m_returns = m_returns + 1;
                        m_dir     = -m_dir;
                        m_ball    = m_ball + m_dir;
                        m_armed   = 0;
                    end else begin
                        if (m_dir > 0) begin
                            if (m_sl < 15) m_sl = m_sl + 1;
                            m_server = 1;
                        end else begin
                            if (m_sr < 15) m_sr = m_sr + 1;
                            m_server = 0;
                        end
                        m_mode  = 2;
                        m_fk    = 0;
                        m_armed = 0;
                    end
                end
            end else begin
                if (tick) begin
                    m_fk = m_fk + 1;
                    if (m_fk == 2 * FC) m_mode = 0;
                end
            end
        end
    end

    function automatic logic [7:0] exp_out();
        if (m_mode == 0) return (m_server == 1) ? 8'h80 : 8'h01;
        if (m_mode == 1) return 8'(1 << m_ball);
        return (m_fk % 2 == 0) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [6:0] exp_hit();
        return 7'((m_returns > 127) ? 127 : m_returns);
    endfunction

    function automatic logic [3:0] exp_level();
        return 4'((m_returns / HPL > 15) ? 15 : m_returns / HPL);
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (cmp_en) begin
            vectors = vectors + 1;
            if (out !== exp_out() || hit !== exp_hit() || level !== exp_level() ||
                score_l !== 4'(m_sl) || score_r !== 4'(m_sr) || busy !== (m_mode != 0)) begin
                errors = errors + 1;
                $display("FAIL cycle_model t=%0t: got out=%h hit=%0d lvl=%0d sl=%0d sr=%0d busy=%0b expected out=%h hit=%0d lvl=%0d sl=%0d sr=%0d busy=%0b",
                         $time, out, hit, level, score_l, score_r, busy,
                         exp_out(), exp_hit(), exp_level(), m_sl, m_sr, (m_mode != 0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors = vectors + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic cyc(input logic bb, input logic pl, input logic pr, input logic tk);
        b = bb; p_l = pl; p_r = pr; tick = tk;
        @(posedge Clk);
        #1;
    endtask

    task automatic travel(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    endtask

    task automatic serve();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic flash_out();
        for (int i = 0; i < 2 * FC; i++) cyc(0, 0, 0, 1);
    endtask

    function automatic bit ball_at_end();
        return (m_mode == 1) && ((m_dir > 0) ? (m_ball == W - 1) : (m_ball == 0));
    endfunction

    // Walk the ball to its current end (bounded), then return it.
    task automatic to_end();
        int guard;
        guard = 0;
        while (!ball_at_end() && guard < 20) begin
            cyc(0, 0, 0, 1);
            guard++;
        end
        if (guard >= 20) begin
            vectors = vectors + 1;
            errors  = errors + 1;
            $display("FAIL to_end_timeout: got no end after %0d ticks expected <= %0d", guard, W);
        end
    endtask

    task automatic do_return(input bit same_cycle);
        bit right;
        to_end();
        right = (m_dir > 0);
        if (same_cycle) begin
            cyc(0, !right, right, 1);
            cyc(0, 0, 0, 0);
        end else begin
            cyc(0, !right, right, 0);
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t expected earlier", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed script ----------------
    logic [7:0] flash_seq [6];

    initial begin
        vectors = 0; errors = 0; cmp_en = 0;
        r_n = 0; b = 0; p_l = 0; p_r = 0; tick = 0;
        flash_seq[0] = 8'h00; flash_seq[1] = 8'hFF; flash_seq[2] = 8'h00;
        flash_seq[3] = 8'hFF; flash_seq[4] = 8'h00; flash_seq[5] = 8'h80;
        repeat (3) @(posedge Clk);
        #1;
        cmp_en = 1;
        check_lit("reset_out", 32'(out), 32'h01);
        check_lit("reset_hit", 32'(hit), 0);
        check_lit("reset_level", 32'(level), 0);
        check_lit("reset_scores", 32'({score_l, score_r}), 0);
        check_lit("reset_busy", 32'(busy), 0);
        r_n = 1;

        // Ticks and paddles in the wait state do nothing.
        cyc(0, 1, 1, 1);
        cyc(0, 0, 0, 1);
        check_lit("wait_ignores_tick", 32'(out), 32'h01);

        // Serve from the left and walk the bar.
        serve();
        check_lit("serve_busy", 32'(busy), 1);
        for (int i = 1; i < W; i++) begin
            cyc(0, 0, 0, 1);
            if (i == 3) cyc(0, 0, 0, 0);
        end
        check_lit("walk_to_pos7", 32'(out), 32'h80);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check_lit("right_return_out", 32'(out), 32'h40);
        check_lit("right_return_hit", 32'(hit), 1);

        travel(6);
        check_lit("walk_to_pos0", 32'(out), 32'h01);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check_lit("left_return_out", 32'(out), 32'h02);
        check_lit("left_return_hit", 32'(hit), 2);

        // Right misses.
        travel(6);
        cyc(0, 0, 0, 1);
        check_lit("miss_score_l", 32'(score_l), 1);
        check_lit("miss_flash_on", 32'(out), 32'hFF);
        for (int k = 0; k < 2 * FC; k++) begin
            if (k == 2) begin
                cyc(1, 1, 1, 0);
                cyc(0, 0, 0, 0);
            end
            cyc(0, 0, 0, 1);
            check_lit($sformatf("flash_step%0d", k), 32'(out), 32'(flash_seq[k]));
        end
        check_lit("after_flash_busy", 32'(busy), 0);
        check_lit("after_flash_hit_held", 32'(hit), 2);

        // Serve from the right.
        serve();
        check_lit("right_serve_out", 32'(out), 32'h80);
        travel(7);
        check_lit("right_serve_pos0", 32'(out), 32'h01);

        // Paddle held from pos5 through pos7 gives no usable edge.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        travel(4);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        check_lit("held_paddle_miss", 32'(score_l), 2);
        cyc(0, 0, 0, 0);
        flash_out();

        // Early pulse at pos6 only is also a miss.
        serve();
        travel(7);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        travel(5);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check_lit("early_paddle_miss", 32'(score_l), 3);
        check_lit("early_paddle_score_r", 32'(score_r), 0);
        flash_out();

        // Leveling and saturation over a long rally.
        serve();
        for (int n = 1; n <= 130; n++) begin
            do_return(n % 2);
            if (n == 4) begin
                check_lit("lvl_after4", 32'(level), 1);
                check_lit("hit_after4", 32'(hit), 4);
            end
            if (n == 59) check_lit("lvl_after59", 32'(level), 14);
            if (n == 60) check_lit("lvl_after60", 32'(level), 15);
            if (n == 127) check_lit("hit_after127", 32'(hit), 127);
        end
        check_lit("hit_saturated", 32'(hit), 127);
        check_lit("lvl_saturated", 32'(level), 15);
        to_end();
        cyc(0, 0, 0, 1);
        check_lit("long_rally_miss_score_r", 32'(score_r), 1);
        flash_out();
        check_lit("wait_hit_held", 32'(hit), 127);
        serve();
        check_lit("new_serve_hit", 32'(hit), 0);
        check_lit("new_serve_level", 32'(level), 0);

        // Asynchronous reset in mid-rally at pos4.
        travel(4);
        check_lit("pre_reset_pos4", 32'(out), 32'h10);
        r_n = 0;
        #1;
        check_lit("async_reset_out", 32'(out), 32'h01);
        check_lit("async_reset_scores", 32'({score_l, score_r}), 0);
        check_lit("async_reset_busy", 32'(busy), 0);
        @(posedge Clk);
        #1;
        r_n = 1;

        // Paddle edge on the same cycle as the deciding tick is a return.
        serve();
        travel(7);
        cyc(0, 0, 1, 1);
        check_lit("same_cycle_return_out", 32'(out), 32'h40);
        check_lit("same_cycle_return_hit", 32'(hit), 1);
        cyc(0, 0, 0, 0);

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
